// File: rtl/pipe_pkg.sv
// Shared defaults, control-bit positions and the entry layout for pipeline stage registers.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int N_DATA = 2;
  localparam int CTRL_W = 4;
  localparam int RD_W   = 4;

  localparam int CTRL_PCSRC    = 0;
  localparam int CTRL_REGWR    = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMWR    = 3;

  typedef struct packed {
    logic [CTRL_W-1:0]             ctrl;
    logic [RD_W-1:0]               rd;
    logic [N_DATA-1:0][DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter; sticks at all-ones and clears only on reset.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and a saturating stall counter.
// Define PIPE_SKID_EN to add one skid entry and make ready_o a pure register output.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int N_DATA = pipe_pkg::N_DATA,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [CTRL_W-1:0]        ctrl_i,
  input  logic [RD_W-1:0]          rd_i,
  input  logic [N_DATA*DATA_W-1:0] data_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [CTRL_W-1:0]        ctrl_o,
  output logic [RD_W-1:0]          rd_o,
  output logic [N_DATA*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  typedef struct packed {
    logic [CTRL_W-1:0]        ctrl;
    logic [RD_W-1:0]          rd;
    logic [N_DATA*DATA_W-1:0] data;
  } entry_t;

  entry_t main_q, main_d;
  logic   valid_q, valid_d;
  entry_t in_e;
  logic   main_load;

  assign in_e      = '{ctrl: ctrl_i, rd: rd_i, data: data_i};
  assign main_load = !valid_q || ready_i;

`ifdef PIPE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;

  assign ready_o = !skid_valid_q;
  assign accept  = valid_i && ready_o;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    main_d       = main_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (main_load) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = accept;
        if (accept) main_d = in_e;
      end
    end else if (accept) begin
      skid_d       = in_e;
      skid_valid_d = 1'b1;
    end
    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // Without a skid, an accept can only happen when main is loading anyway.
  assign ready_o = main_load;

  always_comb begin
    main_d  = main_q;
    valid_d = valid_q;
    if (main_load) begin
      valid_d = valid_i;
      if (valid_i) main_d = in_e;
    end
    if (flush_i) valid_d = 1'b0;
  end
`endif

  // NOTE: payload flops are reset too, because the outputs must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = main_q.ctrl & {CTRL_W{valid_q}};
  assign rd_o    = main_q.rd;
  assign data_o  = main_q.data;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (valid_q && !ready_i),
    .count (stall_cnt_o)
  );

endmodule
